// File: rtl/multi_pkg.sv
// Shared types and sizing helpers for the iterative multiplier.
// The FSM state enum and the iteration/counter width helpers live here.
package multi_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_BPC   = 1;

    // One iteration per BPC-bit chunk of the multiplier.
    function automatic int calcIters(input int width, input int bpc);
        return width / bpc;
    endfunction

    // The counter must hold the full iteration count N, not just N-1.
    function automatic int calcCntWidth(input int iters);
        return $clog2(iters + 1);
    endfunction

endpackage

// File: rtl/multi_iter_if.sv
// Request/response bundle between a multiplier user (master) and the unit (slave).
// Operands are sampled by the unit only on the accepting edge.
interface multi_iter_if #(
    parameter int WIDTH = multi_pkg::DEF_WIDTH
);
    logic                   req;
    logic                   rdy;
    logic                   sgn;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   done;
    logic [2*WIDTH-1:0]     ab;

    modport master (
        output req, sgn, a, b,
        input  rdy, done, ab
    );

    modport slave (
        input  req, sgn, a, b,
        output rdy, done, ab
    );

endinterface

// File: rtl/multi_pp_step.sv
// One combinational shift-and-add step: adds |a| times a BPC-bit multiplier
// chunk, shifted to the chunk's bit position, onto the running accumulator.
module multi_pp_step #(
    parameter int WIDTH = 8,
    parameter int BPC   = 1,
    parameter int IW    = 4
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   aMag_i,
    input  logic [BPC-1:0]     chunk_i,
    input  logic [IW-1:0]      idx_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [2*WIDTH-1:0] aExt;
    logic [2*WIDTH-1:0] chunkExt;
    logic [2*WIDTH-1:0] partial;
    logic [31:0]        shiftAmt;

    // Partial product and its placement never exceed 2*WIDTH bits since BPC <= WIDTH.
    always_comb begin
        aExt     = {{WIDTH{1'b0}}, aMag_i};
        chunkExt = {{(2*WIDTH-BPC){1'b0}}, chunk_i};
        partial  = aExt * chunkExt;
        shiftAmt = 32'(idx_i) * 32'(BPC);
        acc_o    = acc_i + (partial << shiftAmt);
    end

endmodule

// File: rtl/multi_iter.sv
// Iterative signed/unsigned multiplier retiring BPC multiplier bits per clock.
// Operands are converted to magnitudes on acceptance and the sign is restored at the end.
module multi_iter
    import multi_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BPC   = DEF_BPC
) (
    input  logic        clk,
    input  logic        rst,
    multi_iter_if.slave bus
);

    localparam int N  = calcIters(WIDTH, BPC);
    localparam int CW = calcCntWidth(N);

    generate
        if (WIDTH < 2) begin : gBadWidth
            $error("multi_iter: WIDTH must be at least 2");
        end
        if (BPC < 1 || BPC > WIDTH || (WIDTH % BPC) != 0) begin : gBadBpc
            $error("multi_iter: BPC must divide WIDTH");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   aMag_q, aMag_d;
    logic [WIDTH-1:0]   bShift_q, bShift_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               rdy_q, rdy_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] ab_q, ab_d;

    logic               accept;
    logic               lastStep;
    logic [CW-1:0]      chunkIdx;
    logic [2*WIDTH-1:0] accNext;

    // rdy is registered, so it is only ever high while IDLE.
    assign accept   = bus.req && rdy_q;
    assign lastStep = (state_q == BUSY) && (cnt_q == CW'(1));
    assign chunkIdx = CW'(N) - cnt_q;

    multi_pp_step #(
        .WIDTH (WIDTH),
        .BPC   (BPC),
        .IW    (CW)
    ) uStep (
        .acc_i   (acc_q),
        .aMag_i  (aMag_q),
        .chunk_i (bShift_q[BPC-1:0]),
        .idx_i   (chunkIdx),
        .acc_o   (accNext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept)   state_d = BUSY;
            BUSY: if (lastStep) state_d = IDLE;
            default:            state_d = IDLE;
        endcase
    end

    // Datapath and registered outputs; rdy/done are derived from the upcoming state.
    always_comb begin
        aMag_d   = aMag_q;
        bShift_d = bShift_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ab_d     = ab_q;
        rdy_d    = (state_d == IDLE);
        done_d   = lastStep;

        if (accept) begin
            aMag_d   = (bus.sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
            bShift_d = (bus.sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
            neg_d    = bus.sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            acc_d    = '0;
            cnt_d    = CW'(N);
        end else if (state_q == BUSY) begin
            acc_d    = accNext;
            cnt_d    = cnt_q - CW'(1);
            bShift_d = bShift_q >> BPC;
            if (lastStep) begin
                ab_d = neg_q ? -accNext : accNext;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aMag_q   <= '0;
            bShift_q <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            rdy_q    <= 1'b0;
            done_q   <= 1'b0;
            ab_q     <= '0;
        end else begin
            aMag_q   <= aMag_d;
            bShift_q <= bShift_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            rdy_q    <= rdy_d;
            done_q   <= done_d;
            ab_q     <= ab_d;
        end
    end

    assign bus.rdy  = rdy_q;
    assign bus.done = done_q;
    assign bus.ab   = ab_q;

endmodule

// File: tb/tb_multi_iter.sv
// Self-checking bench for multi_iter: a BPC=1 and a BPC=4 instance checked
// against an arithmetic reference model, a vector table and reset/back-to-back sequences.
module tb_multi_iter;

    logic clk;
    logic rst;

    multi_iter_if #(.WIDTH(8)) m1 ();
    multi_iter_if #(.WIDTH(8)) m4 ();

    multi_iter #(.WIDTH(8), .BPC(1)) dut1 (.clk(clk), .rst(rst), .bus(m1));
    multi_iter #(.WIDTH(8), .BPC(4)) dut4 (.clk(clk), .rst(rst), .bus(m4));

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         wide;
        bit         sgn;
        logic [7:0] a;
        logic [7:0] b;
        logic [15:0] expAb;
        int         expLat;
    } vec_t;

    // Reference: plain integer product, truncated to 16 bits.
    function automatic logic [15:0] refMul(input bit sgn, input logic [7:0] a, input logic [7:0] b);
        int p;
        if (sgn) p = int'($signed(a)) * int'($signed(b));
        else     p = int'(a) * int'(b);
        return p[15:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitRdy(input bit wide);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (wide ? m4.rdy : m1.rdy) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("rdy wait", 32'(seen), 32'd1);
    endtask

    task automatic scramble(input bit wide);
        if (wide) begin
            m4.a = 8'($urandom); m4.b = 8'($urandom); m4.sgn = 1'($urandom);
        end else begin
            m1.a = 8'($urandom); m1.b = 8'($urandom); m1.sgn = 1'($urandom);
        end
    endtask

    task automatic waitDone(input bit wide, output logic [15:0] abOut, output int lat,
                            output bit rdyLowOk, output bit timedOut);
        abOut = '0; lat = 0; rdyLowOk = 1'b1; timedOut = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            lat++;
            if (wide ? m4.done : m1.done) begin
                timedOut = 1'b0;
                abOut = wide ? m4.ab : m1.ab;
                break;
            end
            if (wide ? m4.rdy : m1.rdy) rdyLowOk = 1'b0;
            scramble(wide);
        end
    endtask

    // One complete transaction: accept, count latency, verify the single-cycle done.
    task automatic applyStimulus(input string tag, input bit wide, input bit sgn,
                                 input logic [7:0] a, input logic [7:0] b,
                                 input logic [15:0] expAb, input int expLat);
        logic [15:0] got;
        int lat;
        bit rdyOk, tmo;
        waitRdy(wide);
        if (wide) begin m4.req = 1'b1; m4.sgn = sgn; m4.a = a; m4.b = b; end
        else      begin m1.req = 1'b1; m1.sgn = sgn; m1.a = a; m1.b = b; end
        tick();
        if (wide) m4.req = 1'b0; else m1.req = 1'b0;
        scramble(wide);
        waitDone(wide, got, lat, rdyOk, tmo);
        checkOutput({tag, " timeout"}, 32'(tmo), 32'd0);
        checkOutput({tag, " ab"}, 32'(got), 32'(expAb));
        checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, " rdy low while busy"}, 32'(rdyOk), 32'd1);
        tick();
        checkOutput({tag, " done single cycle"}, 32'(wide ? m4.done : m1.done), 32'd0);
    endtask

    task automatic backToBack();
        logic [7:0] pa[3];
        logic [7:0] pb[3];
        bit         ps[3];
        int         accCycle[3];
        int         accIdx, doneIdx, cyc;
        bit         prevRdy, reqNow;
        pa[0] = 8'hC8; pb[0] = 8'h03; ps[0] = 1'b0;
        pa[1] = 8'h9C; pb[1] = 8'hE7; ps[1] = 1'b1;
        pa[2] = 8'hFF; pb[2] = 8'h81; ps[2] = 1'b1;
        accIdx = 0; doneIdx = 0; cyc = 0;
        accCycle[0] = 0; accCycle[1] = 0; accCycle[2] = 0;
        waitRdy(1'b0);
        m1.req = 1'b1; m1.sgn = ps[0]; m1.a = pa[0]; m1.b = pb[0];
        for (int i = 0; i < 80 && doneIdx < 3; i++) begin
            prevRdy = m1.rdy;
            reqNow  = m1.req;
            tick();
            cyc++;
            if (prevRdy && reqNow && accIdx < 3) begin
                accCycle[accIdx] = cyc;
                accIdx++;
            end
            if (m1.done) begin
                checkOutput("b2b ab", 32'(m1.ab), 32'(refMul(ps[doneIdx], pa[doneIdx], pb[doneIdx])));
                doneIdx++;
            end
            if (accIdx >= 3) m1.req = 1'b0;
            if (m1.rdy && accIdx < 3) begin
                m1.sgn = ps[accIdx]; m1.a = pa[accIdx]; m1.b = pb[accIdx];
            end else begin
                scramble(1'b0);
            end
        end
        m1.req = 1'b0;
        checkOutput("b2b accepts", 32'(accIdx), 32'd3);
        checkOutput("b2b dones", 32'(doneIdx), 32'd3);
        checkOutput("b2b spacing 0-1", 32'(accCycle[1] - accCycle[0]), 32'd9);
        checkOutput("b2b spacing 1-2", 32'(accCycle[2] - accCycle[1]), 32'd9);
    endtask

    initial begin
        vec_t vecs[7];
        logic [15:0] got;
        int lat;
        bit rdyOk, tmo, doneSeen;
        bit w, s;
        logic [7:0] ra, rb;

        vecs[0] = '{1'b0, 1'b0, 8'd13,  8'd11,  16'h008F, 8};
        vecs[1] = '{1'b0, 1'b1, 8'hF3,  8'h0B,  16'hFF71, 8};
        vecs[2] = '{1'b0, 1'b1, 8'h80,  8'h80,  16'h4000, 8};
        vecs[3] = '{1'b0, 1'b1, 8'hFF,  8'hFF,  16'h0001, 8};
        vecs[4] = '{1'b1, 1'b0, 8'hFF,  8'hFF,  16'hFE01, 2};
        vecs[5] = '{1'b0, 1'b0, 8'h00,  8'hA5,  16'h0000, 8};
        vecs[6] = '{1'b1, 1'b1, 8'h80,  8'h7F,  16'hC080, 2};

        // Reset with req already high on the BPC=1 unit.
        rst = 1'b1;
        m1.req = 1'b1; m1.sgn = 1'b0; m1.a = 8'd3; m1.b = 8'd5;
        m4.req = 1'b0; m4.sgn = 1'b0; m4.a = 8'd0; m4.b = 8'd0;
        tick();
        tick();
        checkOutput("reset rdy", 32'(m1.rdy), 32'd0);
        checkOutput("reset done", 32'(m1.done), 32'd0);
        checkOutput("reset ab", 32'(m1.ab), 32'd0);
        checkOutput("reset rdy wide", 32'(m4.rdy), 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("release edge not accepted", 32'(m1.rdy), 32'd1);
        tick();
        checkOutput("accepted after release", 32'(m1.rdy), 32'd0);
        m1.req = 1'b0;
        waitDone(1'b0, got, lat, rdyOk, tmo);
        checkOutput("post-reset timeout", 32'(tmo), 32'd0);
        checkOutput("post-reset ab", 32'(got), 32'd15);
        checkOutput("post-reset latency", 32'(lat), 32'd8);

        for (int i = 0; i < 7; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].wide, vecs[i].sgn,
                          vecs[i].a, vecs[i].b, vecs[i].expAb, vecs[i].expLat);
        end
        applyStimulus("nonzero before abort", 1'b0, 1'b0, 8'd7, 8'd9, 16'd63, 8);

        // Reset three cycles into a BUSY transaction.
        waitRdy(1'b0);
        m1.req = 1'b1; m1.sgn = 1'b0; m1.a = 8'h55; m1.b = 8'h33;
        tick();
        m1.req = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        checkOutput("abort rdy", 32'(m1.rdy), 32'd0);
        checkOutput("abort done", 32'(m1.done), 32'd0);
        checkOutput("abort ab", 32'(m1.ab), 32'd0);
        doneSeen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (m1.done) doneSeen = 1'b1;
        end
        rst = 1'b0;
        checkOutput("abort rdy before release edge", 32'(m1.rdy), 32'd0);
        for (int i = 0; i < 10; i++) begin
            if (i == 1) checkOutput("abort rdy after release edge", 32'(m1.rdy), 32'd1);
            tick();
            if (m1.done) doneSeen = 1'b1;
        end
        checkOutput("abort no done", 32'(doneSeen), 32'd0);
        applyStimulus("after abort", 1'b0, 1'b1, 8'h85, 8'h13, refMul(1'b1, 8'h85, 8'h13), 8);

        backToBack();

        for (int i = 0; i < 30; i++) begin
            w  = 1'($urandom);
            s  = 1'($urandom);
            ra = 8'($urandom);
            rb = 8'($urandom);
            applyStimulus($sformatf("rand%0d", i), w, s, ra, rb, refMul(s, ra, rb), w ? 2 : 8);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
